// File: rtl/md5_round_type_4.sv
// md5_round_type_4: registered MD5 round-4 step (I function), one-cycle latency
module md5_round_type_4 (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [31:0]  a_in,
  input  logic [31:0]  b_in,
  input  logic [31:0]  c_in,
  input  logic [31:0]  d_in,
  input  logic [31:0]  k_in,
  input  logic [4:0]   shift_amount,
  input  logic [5:0]   round_num,
  input  logic [511:0] message,
  output logic         out_valid,
  output logic [31:0]  a_out,
  output logic [31:0]  b_out,
  output logic [31:0]  c_out,
  output logic [31:0]  d_out
);
  logic [5:0]  w_g7;
  logic [3:0]  w_g;
  logic [31:0] w_f, w_m, w_t, w_r;
  logic        r_valid;
  logic [31:0] r_a, r_b, r_c, r_d;
  // only the low four bits of 7*i matter, so a 6-bit product suffices
  assign w_g7 = round_num * 6'd7;
  assign w_g  = w_g7[3:0];
  assign w_f  = c_in ^ (b_in | ~d_in);
  assign w_m  = message[{w_g, 5'd0} +: 32];
  assign w_t  = a_in + w_f + k_in + w_m;
  // right shift by (-s mod 32) is the wrap-around half; s=0 reduces to t|t
  assign w_r  = (w_t << shift_amount) | (w_t >> (5'd0 - shift_amount));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_valid <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      r_d <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_a <= d_in;
        r_b <= b_in + w_r;
        r_c <= b_in;
        r_d <= c_in;
      end
    end
  assign out_valid = r_valid;
  assign a_out     = r_a;
  assign b_out     = r_b;
  assign c_out     = r_c;
  assign d_out     = r_d;
endmodule

// File: tb/tb_md5_round_type_4.sv
// tb_md5_round_type_4: directed spec vectors plus randomized steps against a reference model
module tb_md5_round_type_4;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [31:0]  a_in = '0, b_in = '0, c_in = '0, d_in = '0, k_in = '0;
  logic [4:0]   shift_amount = '0;
  logic [5:0]   round_num = '0;
  logic [511:0] message = '0;
  logic         out_valid;
  logic [31:0]  a_out, b_out, c_out, d_out;
  logic [31:0]  mw [16];
  logic [31:0]  e_a, e_b, e_c, e_d;
  logic         e_v;
  int checks = 0;
  int failures = 0;

  md5_round_type_4 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in), .k_in(k_in),
    .shift_amount(shift_amount), .round_num(round_num), .message(message),
    .out_valid(out_valid), .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".v"}, {31'd0, out_valid}, {31'd0, e_v});
    chk({tag, ".a"}, a_out, e_a);
    chk({tag, ".b"}, b_out, e_b);
    chk({tag, ".c"}, c_out, e_c);
    chk({tag, ".d"}, d_out, e_d);
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
    for (int i = 0; i < s; i++) x = {x[30:0], x[31]};
    return x;
  endfunction

  // reference step computed from the MD5 round-4 definition with integer arithmetic
  task automatic model();
    int g;
    logic [31:0] t;
    g = (7 * int'(round_num)) % 16;
    t = a_in + (c_in ^ (b_in | ~d_in)) + k_in + mw[g];
    e_a = d_in;
    e_b = b_in + rotl(t, int'(shift_amount));
    e_c = b_in;
    e_d = c_in;
  endtask

  task automatic load_msg();
    for (int j = 0; j < 16; j++) message[32*j +: 32] = mw[j];
  endtask

  task automatic set_common(input logic [4:0] s, input logic [5:0] r);
    a_in = 32'h67452301; b_in = 32'hefcdab89; c_in = 32'h98badcfe; d_in = 32'h10325476;
    k_in = 32'hd76aa478; shift_amount = s; round_num = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int j = 0; j < 16; j++) mw[j] = j * 32'h11111111;
    load_msg();
    e_v = 1'b0; e_a = '0; e_b = '0; e_c = '0; e_d = '0;
    #12;
    chk_all("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_all("idle");

    set_common(5'd7, 6'd0); in_valid = 1'b1;
    tick();
    e_v = 1'b1; e_a = 32'h10325476; e_b = 32'h036d23e4; e_c = 32'hefcdab89; e_d = 32'h98badcfe;
    chk_all("s1");
    set_common(5'd7, 6'd1);
    tick();
    e_b = 32'hbf28df1f;
    chk_all("s2_b2b");
    set_common(5'd0, 6'd0);
    tick();
    e_b = 32'ha5f4ea79;
    chk_all("s3_norot");
    set_common(5'd7, 6'd48);
    tick();
    e_b = 32'h036d23e4;
    chk_all("s4_wrap48");
    in_valid = 1'b0; set_common(5'd3, 6'd5);
    tick();
    e_v = 1'b0;
    chk_all("hold");
    set_common(5'd7, 6'd63); in_valid = 1'b1;
    model();
    tick();
    e_v = 1'b1;
    chk_all("r63");
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    e_v = 1'b0; e_a = '0; e_b = '0; e_c = '0; e_d = '0;
    chk_all("async_rst");
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 300; n++) begin
      a_in = $urandom; b_in = $urandom; c_in = $urandom; d_in = $urandom; k_in = $urandom;
      shift_amount = 5'($urandom); round_num = 6'($urandom);
      if (n % 37 == 0) begin
        for (int j = 0; j < 16; j++) mw[j] = $urandom;
        load_msg();
      end
      in_valid = ($urandom_range(0, 3) != 0);
      if (in_valid) model();
      e_v = in_valid;
      tick();
      chk_all("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
